// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake into a small FIFO and
// presents them to ID with branch/jump redirects. Optional IF_PERF_CNT_EN adds fetch/stall counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jumpTaken,
    input  logic [25:0] target,
    output logic [31:0] fullInstruction,
    output logic [31:0] pcPlus4,
`ifdef IF_PERF_CNT_EN
    output logic        instrValid,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`else
    output logic        instrValid
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             state_reg;
    logic               drop_reg;
    logic [31:0]        pc_reg;
    logic [31:0]        addr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               valid_reg;
    logic [31:0]        instr_reg;
    logic [31:0]        pc4_reg;

    // Each entry holds {instruction, pc+4}
    logic [63:0]        buf_mem [BUF_DEPTH];

    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               accept;
    logic               load_out;
    logic               pop;
    logic               bypass;
    logic               push_buf;
    logic [31:0]        pc_inc;
    logic [CNT_W-1:0]   count_next;
    logic [63:0]        head;

    assign redirect    = branchTaken | jumpTaken;
    // Branch comes from EX (older instruction), so it wins over a jump from ID
    assign redirect_pc = branchTaken ? (branchTarget & 32'hFFFF_FFFC)
                                     : {pc4_reg[31:28], target, 2'b00};
    assign pc_inc      = pc_reg + 32'd4;
    assign accept      = (state_reg == REQ) && imem_ack && !drop_reg && !redirect;
    assign load_out    = !valid_reg || !id_stall;
    assign pop         = load_out && (count_reg != '0);
    // An empty buffer lets the returning word go straight to the output register
    assign bypass      = load_out && (count_reg == '0) && accept;
    assign push_buf    = accept && !bypass;
    assign count_next  = count_reg + CNT_W'(push_buf) - CNT_W'(pop);
    assign head        = buf_mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push_buf) begin
            buf_mem[wr_ptr_reg] <= {imem_rdata, pc_inc};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            drop_reg   <= 1'b0;
            pc_reg     <= RESET_PC;
            addr_reg   <= RESET_PC;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            instr_reg  <= 32'h0;
            pc4_reg    <= 32'h0;
        end else if (redirect) begin
            pc_reg     <= redirect_pc;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            instr_reg  <= 32'h0;
            pc4_reg    <= 32'h0;
            // An in-flight request must still complete at its old address; its data is dropped
            if (state_reg == REQ) begin
                if (imem_ack) begin
                    state_reg <= IDLE;
                    drop_reg  <= 1'b0;
                end else begin
                    drop_reg  <= 1'b1;
                end
            end
        end else begin
            if (load_out) begin
                if (count_reg != '0) begin
                    valid_reg <= 1'b1;
                    instr_reg <= head[63:32];
                    pc4_reg   <= head[31:0];
                end else if (accept) begin
                    valid_reg <= 1'b1;
                    instr_reg <= imem_rdata;
                    pc4_reg   <= pc_inc;
                end else begin
                    valid_reg <= 1'b0;
                    instr_reg <= 32'h0;
                    pc4_reg   <= 32'h0;
                end
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push_buf) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;

            case (state_reg)
                IDLE: begin
                    if (count_reg < DEPTH_C) begin
                        state_reg <= REQ;
                        addr_reg  <= pc_reg;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        if (drop_reg) begin
                            drop_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            pc_reg <= pc_inc;
                            if (count_next < DEPTH_C) begin
                                addr_reg <= pc_inc;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_reg;
    logic [31:0] stall_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetched_reg <= 32'h0;
            stall_reg   <= 32'h0;
        end else begin
            if (accept) begin
                fetched_reg <= fetched_reg + 32'd1;
            end
            if (valid_reg && id_stall) begin
                stall_reg <= stall_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_reg;
    assign perf_stall   = stall_reg;
`endif

    assign imem_req        = (state_reg == REQ);
    assign imem_addr       = addr_reg;
    assign fullInstruction = instr_reg;
    assign pcPlus4         = pc4_reg;
    assign instrValid      = valid_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a memory model answers each request with addr^32'hA5A5_0000
// after a programmable delay; scenario tasks check delivery order, stalls, redirects and reset.
module tb_if_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = 32'h0;
    logic        jumpTaken = 1'b0;
    logic [25:0] target = 26'h0;
    logic [31:0] fullInstruction;
    logic [31:0] pcPlus4;
    logic        instrValid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int          checks = 0;
    int          errors = 0;
    int          ack_lat = 1;
    int          wait_cnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] exp_addr;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clock(clock),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .id_stall(id_stall),
        .branchTaken(branchTaken),
        .branchTarget(branchTarget),
        .jumpTaken(jumpTaken),
        .target(target),
        .fullInstruction(fullInstruction),
        .pcPlus4(pcPlus4),
`ifdef IF_PERF_CNT_EN
        .instrValid(instrValid),
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`else
        .instrValid(instrValid)
`endif
    );

    always #5 clock = ~clock;

    // Memory model: drives ack/rdata on the falling edge, and checks the address holds during a request
    always @(negedge clock) begin
        if (!reset && imem_req && prev_req && !prev_ack) begin
            checks++;
            if (imem_addr !== prev_addr) begin
                errors++;
                $display("FAIL addr_stable: imem_addr=%h required %h", imem_addr, prev_addr);
            end
        end
        prev_req  = imem_req && !reset;
        prev_addr = imem_addr;
        imem_ack  = 1'b0;
        if (reset || !imem_req) begin
            wait_cnt = 0;
        end else if (wait_cnt >= ack_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ 32'hA5A5_0000;
            wait_cnt   = 0;
        end else begin
            wait_cnt++;
        end
        prev_ack = imem_ack;
    end

    task automatic step_until_valid(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clock);
            #2;
            if (instrValid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #2;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_req: req=%b addr=%h required req=0 addr=00000000", imem_req, imem_addr);
        end
        checks++;
        if (instrValid !== 1'b0 || fullInstruction !== 32'h0 || pcPlus4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: valid=%b instr=%h pc4=%h required 0/0/0", instrValid, fullInstruction, pcPlus4);
        end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin
            errors++;
            $display("FAIL reset_perf: fetched=%0d stall=%0d required 0/0", perf_fetched, perf_stall);
        end
`endif
    endtask

    task automatic test_fetch_stream();
        bit got;
        reset = 1'b0;
        @(posedge clock); #2;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h required req=1 addr=00000000", imem_req, imem_addr);
        end
        @(posedge clock); #2;
        checks++;
        if (instrValid !== 1'b0) begin
            errors++;
            $display("FAIL pre_ack_valid: valid=%b required 0", instrValid);
        end
        @(posedge clock); #2;
        checks++;
        if (instrValid !== 1'b1 || fullInstruction !== 32'hA5A5_0000 || pcPlus4 !== 32'h4) begin
            errors++;
            $display("FAIL first_instr: valid=%b instr=%h pc4=%h required 1/a5a50000/00000004",
                     instrValid, fullInstruction, pcPlus4);
        end
        exp_addr = 32'h4;
        for (int k = 0; k < 4; k++) begin
            step_until_valid(20, got);
            checks++;
            if (!got || fullInstruction !== (exp_addr ^ 32'hA5A5_0000) || pcPlus4 !== exp_addr + 32'd4) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b instr=%h pc4=%h required instr=%h pc4=%h", k,
                         instrValid, fullInstruction, pcPlus4, exp_addr ^ 32'hA5A5_0000, exp_addr + 32'd4);
            end
            exp_addr += 32'd4;
        end
    endtask

    task automatic test_stall();
        bit got;
        logic [31:0] held_i;
        logic [31:0] held_p;
        step_until_valid(20, got);
        checks++;
        if (!got || fullInstruction !== (exp_addr ^ 32'hA5A5_0000) || pcPlus4 !== exp_addr + 32'd4) begin
            errors++;
            $display("FAIL stall_head: valid=%b instr=%h pc4=%h required instr=%h", instrValid,
                     fullInstruction, pcPlus4, exp_addr ^ 32'hA5A5_0000);
        end
        held_i   = fullInstruction;
        held_p   = pcPlus4;
        id_stall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #2;
            checks++;
            if (instrValid !== 1'b1 || fullInstruction !== held_i || pcPlus4 !== held_p) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc4=%h required 1/%h/%h", k,
                         instrValid, fullInstruction, pcPlus4, held_i, held_p);
            end
        end
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_drop: req=%b required 0", imem_req);
        end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (perf_stall !== 32'd6) begin
            errors++;
            $display("FAIL perf_stall: got %0d required 6", perf_stall);
        end
`endif
        id_stall = 1'b0;
        exp_addr += 32'd4;
        for (int k = 0; k < 4; k++) begin
            step_until_valid(20, got);
            checks++;
            if (!got || fullInstruction !== (exp_addr ^ 32'hA5A5_0000) || pcPlus4 !== exp_addr + 32'd4) begin
                errors++;
                $display("FAIL drain[%0d]: valid=%b instr=%h pc4=%h required instr=%h pc4=%h", k,
                         instrValid, fullInstruction, pcPlus4, exp_addr ^ 32'hA5A5_0000, exp_addr + 32'd4);
            end
            exp_addr += 32'd4;
        end
    endtask

    task automatic test_jump();
        bit got;
        bit found;
        reset = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_until_valid(20, got);
            if (got && pcPlus4 === 32'h10) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL jump_setup: pcPlus4=%h never reached required 00000010", pcPlus4);
        end
        jumpTaken = 1'b1;
        target    = 26'h000_0100;
        @(posedge clock); #2;
        jumpTaken = 1'b0;
        checks++;
        if (instrValid !== 1'b0 || fullInstruction !== 32'h0) begin
            errors++;
            $display("FAIL jump_flush: valid=%b instr=%h required 0/00000000", instrValid, fullInstruction);
        end
        step_until_valid(40, got);
        checks++;
        if (!got || fullInstruction !== 32'hA5A5_0400 || pcPlus4 !== 32'h404) begin
            errors++;
            $display("FAIL jump_target: valid=%b instr=%h pc4=%h required a5a50400/00000404",
                     instrValid, fullInstruction, pcPlus4);
        end
    endtask

    task automatic test_branch_delayed();
        bit got;
        bit found;
        ack_lat = 3;
        found   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #2;
            if (imem_req === 1'b1 && wait_cnt < ack_lat) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL branch_setup: req=%b never pending required 1", imem_req);
        end
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0083;
        @(posedge clock); #2;
        branchTaken = 1'b0;
        checks++;
        if (instrValid !== 1'b0) begin
            errors++;
            $display("FAIL branch_flush: valid=%b required 0", instrValid);
        end
        step_until_valid(60, got);
        checks++;
        if (!got || fullInstruction !== 32'hA5A5_0080 || pcPlus4 !== 32'h84) begin
            errors++;
            $display("FAIL branch_target: valid=%b instr=%h pc4=%h required a5a50080/00000084",
                     instrValid, fullInstruction, pcPlus4);
        end
        ack_lat = 1;
    endtask

    task automatic test_branch_and_jump();
        bit got;
        step_until_valid(40, got);
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0200;
        jumpTaken    = 1'b1;
        target       = 26'h3FF_FFFF;
        @(posedge clock); #2;
        branchTaken = 1'b0;
        jumpTaken   = 1'b0;
        step_until_valid(40, got);
        checks++;
        if (!got || fullInstruction !== 32'hA5A5_0200 || pcPlus4 !== 32'h204) begin
            errors++;
            $display("FAIL branch_wins: valid=%b instr=%h pc4=%h required a5a50200/00000204",
                     instrValid, fullInstruction, pcPlus4);
        end
    endtask

    task automatic test_pc_wrap();
        bit got;
        logic [31:0] a;
        branchTaken  = 1'b1;
        branchTarget = 32'hFFFF_FFF8;
        @(posedge clock); #2;
        branchTaken = 1'b0;
        a = 32'hFFFF_FFF8;
        for (int k = 0; k < 3; k++) begin
            step_until_valid(40, got);
            checks++;
            if (!got || fullInstruction !== (a ^ 32'hA5A5_0000) || pcPlus4 !== a + 32'd4) begin
                errors++;
                $display("FAIL pc_wrap[%0d]: valid=%b instr=%h pc4=%h required instr=%h pc4=%h", k,
                         instrValid, fullInstruction, pcPlus4, a ^ 32'hA5A5_0000, a + 32'd4);
            end
            a += 32'd4;
        end
    endtask

    task automatic test_reset_mid_req();
        bit got;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #2;
            if (imem_req === 1'b1 && instrValid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_req_setup: req=%b valid=%b required 1/1", imem_req, instrValid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instrValid !== 1'b0 || fullInstruction !== 32'h0 ||
            pcPlus4 !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: req=%b valid=%b instr=%h pc4=%h addr=%h required all 0",
                     imem_req, instrValid, fullInstruction, pcPlus4, imem_addr);
        end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_perf: fetched=%0d stall=%0d required 0/0", perf_fetched, perf_stall);
        end
`endif
        @(posedge clock); #2;
        reset = 1'b0;
        step_until_valid(20, got);
        checks++;
        if (!got || fullInstruction !== 32'hA5A5_0000 || pcPlus4 !== 32'h4) begin
            errors++;
            $display("FAIL refetch: valid=%b instr=%h pc4=%h required a5a50000/00000004",
                     instrValid, fullInstruction, pcPlus4);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_stall();
        test_jump();
        test_branch_delayed();
        test_branch_and_jump();
        test_pc_wrap();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
